// File: rtl/mac_stream_engine.sv
// mac_stream_engine
//   Streaming multiply-accumulate engine. A go in IDLE captures a term count
//   (clamped to N_TERMS) and a chain flag. Operand pairs are then accepted over
//   a valid/ready handshake. Each accepted pair is multiplied in one stage and
//   added into the accumulator in the next stage. The result and a sticky
//   overflow flag are published together with a one-cycle done pulse.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   go       : start request, sampled in IDLE only
//   len      : term count, sampled with go (values above N_TERMS clamp)
//   chain    : sampled with go; 0 clears acc/ovf, 1 continues from them
//   in_valid : operand pair valid
//   in_ready : pair accepted this cycle (high throughout RUN)
//   a, b     : operands (unsigned or two's complement per SIGNED)
//   busy     : high in every state except IDLE
//   out      : registered result, holds until the next done
//   ovf      : sticky wrap flag, registered together with out
//   done     : one-cycle pulse when out/ovf update
module mac_stream_engine #(
  parameter int DATA_W  = 4,
  parameter int N_TERMS = 16,
  parameter int SIGNED  = 0,
  localparam int LEN_W  = $clog2(N_TERMS + 1),
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  input  logic              chain,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [ACC_W-1:0]  out,
  output logic              ovf,
  output logic              done
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [PROD_W-1:0]   r_prod;
  logic                r_prod_vld;
  logic [LEN_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_out;
  logic                r_ovf_acc;
  logic                r_ovf;
  logic                r_done;

  logic [LEN_W-1:0]    w_len_clamp;
  logic                w_accept;
  logic [PROD_W-1:0]   w_prod_u;
  logic [PROD_W-1:0]   w_prod_s;
  logic [PROD_W-1:0]   w_prod;
  logic                w_fill;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W:0]      w_sum_wide;
  logic [ACC_W-1:0]    w_sum;
  logic                w_wrap;

  assign w_len_clamp = (len > LEN_W'(N_TERMS)) ? LEN_W'(N_TERMS) : len;
  assign in_ready    = (r_state == RUN);
  assign w_accept    = in_valid && in_ready;

  // Operands are pre-extended to the product width so the multiply is done
  // at full width in both signedness modes.
  assign w_prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign w_prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                    $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign w_prod   = (SIGNED != 0) ? w_prod_s : w_prod_u;

  assign w_fill     = (SIGNED != 0) && r_prod[PROD_W-1];
  assign w_prod_ext = {{(ACC_W - PROD_W){w_fill}}, r_prod};

  // One extra bit captures the unsigned carry; signed overflow is the usual
  // same-sign-operands / different-sign-result test.
  assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum      = w_sum_wide[ACC_W-1:0];
  assign w_wrap     = (SIGNED != 0) ?
                      ((r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1])) :
                      w_sum_wide[ACC_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_ovf_acc  <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Accumulate stage runs independently of the FSM; prod_vld is never
      // set in IDLE, so the chain=0 clear below cannot collide with it.
      if (r_prod_vld) begin
        r_acc <= w_sum;
        if (w_wrap) begin
          r_ovf_acc <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (go) begin
            r_cnt <= w_len_clamp;
            if (!chain) begin
              r_acc     <= '0;
              r_ovf_acc <= 1'b0;
            end
            r_state <= (w_len_clamp != '0) ? RUN : FLUSH;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_prod     <= w_prod;
            r_prod_vld <= 1'b1;
            r_cnt      <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state <= FLUSH;
            end
          end else begin
            r_prod_vld <= 1'b0;
          end
        end
        FLUSH: begin
          r_prod_vld <= 1'b0;
          r_state    <= DONE;
        end
        DONE: begin
          r_out   <= r_acc;
          r_ovf   <= r_ovf_acc;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign out  = r_out;
  assign ovf  = r_ovf;
  assign done = r_done;

endmodule

// File: tb/tb_mac_stream_engine.sv
// tb_mac_stream_engine
//   Directed bench for mac_stream_engine. An unsigned and a signed instance
//   share one stimulus stream; each test checks whichever instance it targets.
module tb_mac_stream_engine;

  logic        clk;
  logic        rst;
  logic        go;
  logic [4:0]  len;
  logic        chain;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;

  logic        in_ready,   in_ready_s;
  logic        busy,       busy_s;
  logic [11:0] out,        out_s;
  logic        ovf,        ovf_s;
  logic        done,       done_s;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] pa [0:31];
  logic [3:0] pb [0:31];

  mac_stream_engine #(.DATA_W(4), .N_TERMS(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .go(go), .len(len), .chain(chain),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .busy(busy), .out(out), .ovf(ovf), .done(done)
  );

  mac_stream_engine #(.DATA_W(4), .N_TERMS(16), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .go(go), .len(len), .chain(chain),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
    .busy(busy_s), .out(out_s), .ovf(ovf_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Called at #1 after an edge. Issues go now, feeds n pairs from pa/pb
  // (every other cycle when gap=1), waits for done and checks the result.
  task automatic run_op(input string tag, input int len_i, input bit chain_i,
                        input int n, input int gap, input bit use_s,
                        input logic [11:0] exp_out, input bit exp_ovf,
                        input int exp_edges, input bit check_pulse);
    int  edges;
    int  idx;
    int  k;
    bit  seen;
    bit  v;
    bit  acc;
    go       = 1'b1;
    len      = 5'(len_i);
    chain    = chain_i;
    in_valid = 1'b0;
    @(posedge clk); #1;
    go    = 1'b0;
    edges = 0;
    idx   = 0;
    k     = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      v        = (idx < n) && (gap == 0 || (k % 2) == 0);
      in_valid = v;
      a        = (idx < n) ? pa[idx] : 4'd0;
      b        = (idx < n) ? pb[idx] : 4'd0;
      acc      = v && (use_s ? in_ready_s : in_ready);
      @(posedge clk); #1;
      edges++;
      k++;
      if (acc) idx++;
      if (use_s ? done_s : done) seen = 1'b1;
    end
    in_valid = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"},   32'(edges), 32'(exp_edges));
    check_eq({tag, "_out"},       32'(use_s ? out_s : out), 32'(exp_out));
    check_eq({tag, "_ovf"},       32'(use_s ? ovf_s : ovf), 32'(exp_ovf));
    check_eq({tag, "_idle"},      32'(use_s ? busy_s : busy), 32'd0);
    if (check_pulse) begin
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, 32'(use_s ? done_s : done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; len = '0; chain = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out",      32'(out),      32'd0);
    check_eq("rst_ovf",      32'(ovf),      32'd0);
    check_eq("rst_done",     32'(done),     32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned burst: 15+14+225+1 = 255
    pa[0] = 4'd3;  pb[0] = 4'd5;
    pa[1] = 4'd2;  pb[1] = 4'd7;
    pa[2] = 4'd15; pb[2] = 4'd15;
    pa[3] = 4'd1;  pb[3] = 4'd1;
    run_op("burst4", 4, 1'b0, 4, 0, 1'b0, 12'd255, 1'b0, 6, 1'b1);

    // Reset mid-RUN after 3 accepts of len=8
    go = 1'b1; len = 5'd8; chain = 1'b0;
    @(posedge clk); #1;
    go = 1'b0; in_valid = 1'b1; a = 4'd1; b = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("midrun_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_out",      32'(out),      32'd0);
    check_eq("abort_done",     32'(done),     32'd0);
    check_eq("abort_busy",     32'(busy),     32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("quiet_busy", 32'(busy), 32'd0);
      check_eq("quiet_done", 32'(done), 32'd0);
    end
    check_eq("quiet_out", 32'(out), 32'd0);

    // Bubbles: 3 x 16 = 48, third accept at E5, done after E7
    for (int i = 0; i < 3; i++) begin pa[i] = 4'd4; pb[i] = 4'd4; end
    run_op("bubble", 3, 1'b0, 3, 1, 1'b0, 12'd48, 1'b0, 7, 1'b1);

    // Clamp 20 -> 16: 16 x 225 = 3600
    for (int i = 0; i < 16; i++) begin pa[i] = 4'd15; pb[i] = 4'd15; end
    run_op("clamp", 20, 1'b0, 16, 0, 1'b0, 12'hE10, 1'b0, 18, 1'b1);

    // Chain: 7200 mod 4096 = 3104 with wrap
    run_op("chain", 16, 1'b1, 16, 0, 1'b0, 12'd3104, 1'b1, 18, 1'b1);

    // Fresh op clears the sticky flag
    pa[0] = 4'd2; pb[0] = 4'd3;
    run_op("fresh", 1, 1'b0, 1, 0, 1'b0, 12'd6, 1'b0, 3, 1'b1);

    // Signed: -56 + 1 = -55
    pa[0] = 4'h8; pb[0] = 4'h7;
    pa[1] = 4'hF; pb[1] = 4'hF;
    run_op("signed", 2, 1'b0, 2, 0, 1'b1, 12'hFC9, 1'b0, 4, 1'b1);

    // len=0 then go during its done cycle
    run_op("len0", 0, 1'b0, 0, 0, 1'b0, 12'd0, 1'b0, 2, 1'b0);
    pa[0] = 4'd2; pb[0] = 4'd2;
    run_op("b2b", 1, 1'b0, 1, 0, 1'b0, 12'd4, 1'b0, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
